axi_lite_mem_frontend: RTL and testbench

AXI4-Lite slave front-end that converts AXI4-Lite read and write transactions into the single-port, byte-strobed block-RAM interface (wen/wstrb/wdata/ren/addr/rdata) used by the register/memory stores in this IP library.
- Sits directly upstream of the memory; the memory has 1-cycle registered read latency.
- One transaction is outstanding at a time.
- Reads and writes are arbitrated round-robin.

---
 rtl/axi_lite_mem_frontend.sv | 209 ++++++++++++++++++++
 tb/tb_axi_lite_mem_frontend.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_frontend.sv
// AXI4-Lite slave that turns read/write transactions into single-port byte-strobed
// block-RAM accesses. One transaction at a time, reads and writes granted round-robin.
//
//   state  | meaning
//   IDLE   | evaluate requests, pick a side, latch address/data
//   W_ACC  | accept AW/W, pulse mem_wen
//   W_RESP | present write response until bready
//   R_ACC  | accept AR, pulse mem_ren
//   R_WAIT | memory read latency, capture mem_rdata
//   R_RESP | present read data until rready
module axi_lite_mem_frontend #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 16,
   parameter int OPT_MEM_ADDR_BITS  = 9
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic                              mem_wen,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   mem_wstrb,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     mem_wdata,
   output logic                              mem_ren,
   output logic [OPT_MEM_ADDR_BITS:0]        mem_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     mem_rdata
);

   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = OPT_MEM_ADDR_BITS + 1;

   typedef enum logic [2:0] {IDLE, W_ACC, W_RESP, R_ACC, R_WAIT, R_RESP} state_t;

   state_t                          state_q, state_d;
   logic                            last_grant_wr_q, last_grant_wr_d;
   logic                            oor_q, oor_d;
   logic                            awready_q, awready_d;
   logic                            wready_q, wready_d;
   logic                            bvalid_q, bvalid_d;
   logic [1:0]                      bresp_q, bresp_d;
   logic                            arready_q, arready_d;
   logic                            rvalid_q, rvalid_d;
   logic [1:0]                      rresp_q, rresp_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                            mem_wen_q, mem_wen_d;
   logic                            mem_ren_q, mem_ren_d;
   logic [STRB_W-1:0]               mem_wstrb_q, mem_wstrb_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic [IDX_W-1:0]                mem_addr_q, mem_addr_d;

   logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_word, ar_word;
   logic [IDX_W-1:0]                aw_idx, ar_idx;
   logic                            aw_oor, ar_oor;
   logic                            write_req, read_req, grant_wr, grant_rd;

   // Byte-offset bits are dropped; anything above the word index is out of range.
   always_comb begin
      aw_word = s_axi_awaddr >> ADDR_LSB;
      ar_word = s_axi_araddr >> ADDR_LSB;
      aw_idx  = aw_word[IDX_W-1:0];
      ar_idx  = ar_word[IDX_W-1:0];
      aw_oor  = |(aw_word >> IDX_W);
      ar_oor  = |(ar_word >> IDX_W);
   end

   always_comb begin
      state_d         = state_q;
      last_grant_wr_d = last_grant_wr_q;
      oor_d           = oor_q;
      awready_d       = 1'b0;
      wready_d        = 1'b0;
      arready_d       = 1'b0;
      mem_wen_d       = 1'b0;
      mem_ren_d       = 1'b0;
      bvalid_d        = bvalid_q;
      bresp_d         = bresp_q;
      rvalid_d        = rvalid_q;
      rresp_d         = rresp_q;
      rdata_d         = rdata_q;
      mem_wstrb_d     = mem_wstrb_q;
      mem_wdata_d     = mem_wdata_q;
      mem_addr_d      = mem_addr_q;
      write_req       = s_axi_awvalid & s_axi_wvalid;
      read_req        = s_axi_arvalid;
      grant_wr        = 1'b0;
      grant_rd        = 1'b0;

      case (state_q)
         IDLE: begin
            // Under contention the side that did not win last time goes first.
            grant_wr = write_req & (~read_req | ~last_grant_wr_q);
            grant_rd = read_req & ~grant_wr;
            if (grant_wr) begin
               mem_addr_d      = aw_idx;
               oor_d           = aw_oor;
               last_grant_wr_d = 1'b1;
               mem_wdata_d     = s_axi_wdata;
               mem_wstrb_d     = s_axi_wstrb;
               awready_d       = 1'b1;
               wready_d        = 1'b1;
               mem_wen_d       = ~aw_oor;
               state_d         = W_ACC;
            end else if (grant_rd) begin
               mem_addr_d      = ar_idx;
               oor_d           = ar_oor;
               last_grant_wr_d = 1'b0;
               arready_d       = 1'b1;
               mem_ren_d       = ~ar_oor;
               state_d         = R_ACC;
            end
         end
         W_ACC: begin
            bvalid_d = 1'b1;
            bresp_d  = oor_q ? 2'b10 : 2'b00;
            state_d  = W_RESP;
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         R_ACC: begin
            state_d = R_WAIT;
         end
         R_WAIT: begin
            rdata_d  = oor_q ? '0 : mem_rdata;
            rresp_d  = oor_q ? 2'b10 : 2'b00;
            rvalid_d = 1'b1;
            state_d  = R_RESP;
         end
         R_RESP: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         last_grant_wr_q <= 1'b0;
         oor_q           <= 1'b0;
         awready_q       <= 1'b0;
         wready_q        <= 1'b0;
         bvalid_q        <= 1'b0;
         bresp_q         <= 2'b00;
         arready_q       <= 1'b0;
         rvalid_q        <= 1'b0;
         rresp_q         <= 2'b00;
         rdata_q         <= '0;
         mem_wen_q       <= 1'b0;
         mem_ren_q       <= 1'b0;
         mem_wstrb_q     <= '0;
         mem_wdata_q     <= '0;
         mem_addr_q      <= '0;
      end else begin
         state_q         <= state_d;
         last_grant_wr_q <= last_grant_wr_d;
         oor_q           <= oor_d;
         awready_q       <= awready_d;
         wready_q        <= wready_d;
         bvalid_q        <= bvalid_d;
         bresp_q         <= bresp_d;
         arready_q       <= arready_d;
         rvalid_q        <= rvalid_d;
         rresp_q         <= rresp_d;
         rdata_q         <= rdata_d;
         mem_wen_q       <= mem_wen_d;
         mem_ren_q       <= mem_ren_d;
         mem_wstrb_q     <= mem_wstrb_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_addr_q      <= mem_addr_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign mem_wen       = mem_wen_q;
   assign mem_ren       = mem_ren_q;
   assign mem_wstrb     = mem_wstrb_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_axi_lite_mem_frontend.sv
// Self-checking bench for axi_lite_mem_frontend: directed vector table plus
// hand-written contention, backpressure and mid-transaction reset sequences.
module tb_axi_lite_mem_frontend;

   logic        clk;
   logic        rst_n;
   logic [15:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [15:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        mem_wen;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ren;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;
   int overlap = 0;

   axi_lite_mem_frontend #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(16),
      .OPT_MEM_ADDR_BITS(9)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ren(mem_ren),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Block RAM behind the front-end: byte-strobed write, 1-cycle registered read.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (mem_wen)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_ren) mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk)
      if (rst_n && mem_wen && mem_ren) overlap++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat_a, output int lat_b, output int en_cnt,
                           output logic [9:0] en_addr, output logic [1:0] resp);
      lat_a = -1; lat_b = -1; en_cnt = 0; en_addr = '0; resp = 2'b11;
      @(negedge clk);
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_wen) begin en_cnt++; en_addr = mem_addr; end
         if (s_axi_awready && s_axi_wready && lat_a < 0) begin
            lat_a = c; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
         end
         if (s_axi_bvalid) begin lat_b = c; resp = s_axi_bresp; break; end
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] a, output int lat_a, output int lat_r,
                          output int en_cnt, output logic [9:0] en_addr,
                          output logic [1:0] resp, output logic [31:0] data);
      lat_a = -1; lat_r = -1; en_cnt = 0; en_addr = '0; resp = 2'b11; data = 32'hFFFF_FFFF;
      @(negedge clk);
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_ren) begin en_cnt++; en_addr = mem_addr; end
         if (s_axi_arready && lat_a < 0) begin lat_a = c; s_axi_arvalid = 1'b0; end
         if (s_axi_rvalid) begin lat_r = c; resp = s_axi_rresp; data = s_axi_rdata; break; end
      end
      s_axi_arvalid = 1'b0;
   endtask

   function automatic logic any_out();
      return |{s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
               s_axi_rvalid, s_axi_rresp, s_axi_rdata, mem_wen, mem_ren, mem_wstrb,
               mem_wdata, mem_addr};
   endfunction

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  exp_resp;
      logic        exp_en;
      logic [9:0]  exp_maddr;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int          la, lb, en;
      logic [9:0]  ea;
      logic [1:0]  rsp;
      logic [31:0] rd;
      int          gcnt, ok, seen;
      logic [2:0]  gseq;
      logic        first_wr;

      vecs[0]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1, 10'd2,     32'h0};
      vecs[1]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 2'b00, 1'b1, 10'd2,     32'hDEADBEEF};
      vecs[2]  = '{1'b1, 16'h0000, 32'h11223344, 4'hF, 2'b00, 1'b1, 10'd0,     32'h0};
      vecs[3]  = '{1'b1, 16'h0000, 32'hAABBCCDD, 4'h5, 2'b00, 1'b1, 10'd0,     32'h0};
      vecs[4]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 1'b1, 10'd0,     32'h11BB33DD};
      vecs[5]  = '{1'b1, 16'h1000, 32'h12345678, 4'hF, 2'b10, 1'b0, 10'd0,     32'h0};
      vecs[6]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 2'b10, 1'b0, 10'd0,     32'h0};
      vecs[7]  = '{1'b1, 16'h0FFE, 32'hCAFEF00D, 4'hF, 2'b00, 1'b1, 10'h3FF,   32'h0};
      vecs[8]  = '{1'b0, 16'h0FFC, 32'h0,        4'h0, 2'b00, 1'b1, 10'h3FF,   32'hCAFEF00D};
      vecs[9]  = '{1'b0, 16'h8004, 32'h0,        4'h0, 2'b10, 1'b0, 10'd0,     32'h0};
      vecs[10] = '{1'b0, 16'h0001, 32'h0,        4'h0, 2'b00, 1'b1, 10'd0,     32'h11BB33DD};

      rst_n = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs_zero", any_out(), 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, la, lb, en, ea, rsp);
            check($sformatf("vec%0d_aw_latency", i), la, 1);
            check($sformatf("vec%0d_b_latency", i), lb, 2);
         end else begin
            do_read(vecs[i].addr, la, lb, en, ea, rsp, rd);
            check($sformatf("vec%0d_ar_latency", i), la, 1);
            check($sformatf("vec%0d_r_latency", i), lb, 3);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         end
         check($sformatf("vec%0d_resp", i), rsp, vecs[i].exp_resp);
         check($sformatf("vec%0d_mem_en_count", i), en, {63'b0, vecs[i].exp_en});
         if (vecs[i].exp_en) check($sformatf("vec%0d_mem_addr", i), ea, vecs[i].exp_maddr);
      end

      // Contention: all three valids held together; last grant was a read.
      @(negedge clk);
      s_axi_awaddr = 16'h0010; s_axi_wdata = 32'h00C0FFEE; s_axi_wstrb = 4'hF;
      s_axi_araddr = 16'h0008; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      gcnt = 0; gseq = '0;
      for (int c = 0; c < 40 && gcnt < 3; c++) begin
         @(negedge clk);
         if (s_axi_awready) begin gseq[gcnt] = 1'b1; gcnt++; end
         else if (s_axi_arready) begin gseq[gcnt] = 1'b0; gcnt++; end
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      check("contention_grant_count", gcnt, 3);
      check("contention_order_w_r_w", gseq, 3'b101);
      repeat (6) @(negedge clk);

      // Write response backpressure, with a read pending.
      s_axi_awaddr = 16'h0014; s_axi_wdata = 32'h0BADCAFE; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_awready) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
         if (s_axi_bvalid) begin seen = 1; break; end
      end
      check("bp_bvalid_seen", seen, 1);
      s_axi_araddr = 16'h0014; s_axi_arvalid = 1'b1; ok = 0;
      repeat (5) begin
         @(negedge clk);
         if (s_axi_bvalid && s_axi_bresp == 2'b00 && !s_axi_arready && !s_axi_awready) ok++;
      end
      check("bp_b_held_5_cycles", ok, 5);
      s_axi_bready = 1'b1;
      @(negedge clk);
      check("bp_bvalid_released", s_axi_bvalid, 1'b0);

      // Read data backpressure, with a write pending.
      s_axi_rready = 1'b0; seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_arready) s_axi_arvalid = 1'b0;
         if (s_axi_rvalid) begin seen = 1; break; end
      end
      check("bp_rvalid_seen", seen, 1);
      s_axi_awaddr = 16'h0018; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; ok = 0;
      repeat (5) begin
         @(negedge clk);
         if (s_axi_rvalid && s_axi_rdata == 32'h0BADCAFE && s_axi_rresp == 2'b00 &&
             !s_axi_awready && !s_axi_arready) ok++;
      end
      check("bp_r_held_5_cycles", ok, 5);
      s_axi_rready = 1'b1; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      @(negedge clk);
      check("bp_rvalid_released", s_axi_rvalid, 1'b0);
      repeat (2) @(negedge clk);

      // Reset while the read is waiting on memory.
      s_axi_araddr = 16'h0008; s_axi_arvalid = 1'b1; seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_arready) begin s_axi_arvalid = 1'b0; seen = 1; break; end
      end
      check("rst_read_accepted", seen, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs_zero", any_out(), 1'b0);
      rst_n = 1'b1; ok = 0;
      repeat (4) begin
         @(negedge clk);
         if (s_axi_rvalid) ok++;
      end
      check("rst_no_rvalid", ok, 0);

      s_axi_awaddr = 16'h001C; s_axi_wdata = 32'h600DD00D; s_axi_wstrb = 4'hF;
      s_axi_araddr = 16'h0008; s_axi_bready = 1'b1;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      seen = 0; first_wr = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_awready || s_axi_arready) begin
            first_wr = s_axi_awready; seen = 1;
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
            break;
         end
      end
      check("rst_first_grant_write", {seen[0], first_wr}, 2'b11);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_bvalid) begin seen = 1; rsp = s_axi_bresp; break; end
      end
      check("rst_write_bvalid", seen, 1);
      check("rst_write_bresp", rsp, 2'b00);
      do_read(16'h001C, la, lb, en, ea, rsp, rd);
      check("rst_readback", rd, 32'h600DD00D);

      check("no_wen_ren_overlap", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
